// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, synchronous-read instruction
// memory requests, one-entry skid buffer and the fetch/decode register.
// op/cond are decoded combinationally from instr_D for controlUnit.
module fetch_stage #(
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               valid_D,
    output logic [ADDR_W-1:0]  pc_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [3:0]         op,
    output logic               cond
);

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

    skid_state_t        skid_state;
    logic               skid_v;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic [ADDR_W-1:0]  pc_F;
    logic               inf_v;
    logic [ADDR_W-1:0]  inf_pc;

    logic               skid_capture;

    // A request goes out unless held in reset, stalled or being redirected.
    assign imem_req  = !rst && !stall && !PCSrc;
    assign imem_addr = pc_F;

    assign skid_v       = (skid_state == SKID_FULL);
    assign skid_capture = !rst && !PCSrc && stall && inf_v && !skid_v;

    // Fields consumed by controlUnit.
    assign op   = instr_D[INSTR_W-1 -: 4];
    assign cond = instr_D[INSTR_W-5];

    // Control state: PC, in-flight flag, skid FSM and the decode register.
    // NOTE: all state is updated with <= so every register samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_F       <= RESET_PC;
            inf_v      <= 1'b0;
            skid_state <= SKID_EMPTY;
            valid_D    <= 1'b0;
            pc_D       <= '0;
            instr_D    <= NOP_INSTR;
        end else if (PCSrc) begin
            // Redirect outranks stall: flush everything younger than the branch.
            pc_F       <= branch_target;
            inf_v      <= 1'b0;
            skid_state <= SKID_EMPTY;
            valid_D    <= 1'b0;
            instr_D    <= NOP_INSTR;
        end else begin
            if (stall) begin
                inf_v <= 1'b0;
            end else begin
                inf_v <= 1'b1;
                pc_F  <= pc_F + ADDR_W'(1);
            end

            case (skid_state)
                SKID_EMPTY: if (stall && inf_v) skid_state <= SKID_FULL;
                SKID_FULL:  if (!stall)         skid_state <= SKID_EMPTY;
            endcase

            if (!stall) begin
                if (skid_v) begin
                    valid_D <= 1'b1;
                    pc_D    <= skid_pc;
                    instr_D <= skid_instr;
                end else if (inf_v) begin
                    valid_D <= 1'b1;
                    pc_D    <= inf_pc;
                    instr_D <= imem_rdata;
                end else begin
                    valid_D <= 1'b0;
                    instr_D <= NOP_INSTR;
                end
            end
        end
    end

    // Payload registers for the in-flight request and the skid entry.
    // NOTE: these carry no reset; their contents are only ever consumed
    // while the matching valid flag is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            inf_pc <= pc_F;
        end
        if (skid_capture) begin
            skid_pc    <= inf_pc;
            skid_instr <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage: a per-cycle vector table for
// reset/run/stall/branch, followed by hand-written multi-cycle sequences for
// branch-while-stalled, PC wrap and mid-stream reset.
module tb_fetch_stage;

    localparam int unsigned        ADDR_W  = 16;
    localparam int unsigned        INSTR_W = 32;
    localparam logic [ADDR_W-1:0]  RST_PC  = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP     = 32'hE000_0000;

    logic               clk;
    logic               rst;
    logic               stall;
    logic               PCSrc;
    logic [ADDR_W-1:0]  branch_target;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               valid_D;
    logic [ADDR_W-1:0]  pc_D;
    logic [INSTR_W-1:0] instr_D;
    logic [3:0]         op;
    logic               cond;

    fetch_stage #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .valid_D       (valid_D),
        .pc_D          (pc_D),
        .instr_D       (instr_D),
        .op            (op),
        .cond          (cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: distinct op/cond per address, address in the low half.
    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a[3:0], a[1], 11'h0A5, a};
    endfunction

    // Synchronous-read memory; garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic              rst;
        logic              stall;
        logic              pcsrc;
        logic [ADDR_W-1:0] tgt;
        logic              exp_req;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_v;
        logic              pc_known;
        logic [ADDR_W-1:0] exp_pc;
        logic              exp_skid;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;
    int cur_row    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s row %0d: got %h want %h", name, cur_row, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic [ADDR_W-1:0] t, input logic req,
                                input logic [ADDR_W-1:0] addr, input logic v,
                                input logic pk, input logic [ADDR_W-1:0] pc,
                                input logic sk);
        vec_t x;
        x.rst = r; x.stall = s; x.pcsrc = p; x.tgt = t;
        x.exp_req = req; x.exp_addr = addr; x.exp_v = v;
        x.pc_known = pk | v; x.exp_pc = pc; x.exp_skid = sk;
        return x;
    endfunction

    // Drive one cycle's inputs, compare on the falling edge, advance a cycle.
    task automatic apply(input vec_t x);
        logic [INSTR_W-1:0] exp_instr;
        rst           = x.rst;
        stall         = x.stall;
        PCSrc         = x.pcsrc;
        branch_target = x.tgt;
        @(negedge clk);
        exp_instr = x.exp_v ? mem_word(x.exp_pc) : NOP;
        check("imem_req",  32'(imem_req),  32'(x.exp_req));
        check("imem_addr", 32'(imem_addr), 32'(x.exp_addr));
        check("valid_D",   32'(valid_D),   32'(x.exp_v));
        if (x.pc_known) check("pc_D", 32'(pc_D), 32'(x.exp_pc));
        check("instr_D",   instr_D,        exp_instr);
        check("op",        32'(op),        32'(exp_instr[31:28]));
        check("cond",      32'(cond),      32'(exp_instr[27]));
        check("skid_v",    32'(dut.skid_v), 32'(x.exp_skid));
        cur_row++;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; stall = 1'b0; PCSrc = 1'b0; branch_target = '0;
        @(posedge clk);
        #1;

        //            rst stl pcs tgt       req addr      v pk pc        skid
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0)); // reset held
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000, 0)); // c0
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000, 0)); // c1
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0000, 0)); // c2 first valid
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0003, 1, 0, 16'h0001, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0004, 1, 0, 16'h0002, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0005, 1, 0, 16'h0003, 0)); // c5 one-cycle stall
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0005, 1, 0, 16'h0003, 1)); // held, skid full
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0006, 1, 0, 16'h0004, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0007, 1, 0, 16'h0005, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0008, 1, 0, 16'h0006, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0009, 1, 0, 16'h0007, 0)); // c10 long stall
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0009, 1, 0, 16'h0007, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0009, 1, 0, 16'h0007, 1)); // c15 release
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000A, 1, 0, 16'h0008, 0)); // skid entry
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h000B, 1, 0, 16'h0009, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 16'h000C, 1, 0, 16'h000A, 0)); // c18 branch
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0040, 0, 0, 16'h0000, 0)); // bubble
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0041, 0, 0, 16'h0000, 0)); // bubble
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0042, 1, 0, 16'h0040, 0)); // target
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0043, 1, 0, 16'h0041, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Branch while stalled with a full skid: skid entry 0x43 is dropped.
        apply(mk(0, 1, 0, 16'h0000, 0, 16'h0044, 1, 0, 16'h0042, 0));
        apply(mk(0, 1, 0, 16'h0000, 0, 16'h0044, 1, 0, 16'h0042, 1));
        apply(mk(0, 1, 1, 16'h0100, 0, 16'h0044, 1, 0, 16'h0042, 1));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0100, 0, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0101, 0, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0102, 1, 0, 16'h0100, 0));

        // PC wrap from 0xFFFE.
        apply(mk(0, 0, 1, 16'hFFFE, 0, 16'h0103, 1, 0, 16'h0101, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 1, 0, 16'hFFFE, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0001, 1, 0, 16'hFFFF, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0000, 0));

        // Fill the skid, then a one-cycle reset must discard it and restart.
        apply(mk(0, 1, 0, 16'h0000, 0, 16'h0003, 1, 0, 16'h0001, 0));
        apply(mk(1, 0, 0, 16'h0000, 0, 16'h0003, 1, 0, 16'h0001, 1));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 16'h0000, 0));
        apply(mk(0, 0, 0, 16'h0000, 1, 16'h0003, 1, 0, 16'h0001, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the vector processor. Holds the program counter, issues word-address requests to a synchronous-read instruction memory, and registers the returned instruction into the fetch/decode pipeline register. It sits directly upstream of `controlUnit`. Its `op` and `cond` outputs feed that unit, and it takes `PCSrc` and the branch target back from it. A one-entry skid buffer ensures no fetched instruction is lost while the decode side is stalled.

## Interface
**Parameters**
- `ADDR_W`, default 16: PC and instruction-address width, in words.
- `INSTR_W`, default 32: instruction width, minimum 28.
- `RESET_PC`, default 0: first fetch address after reset.
- `NOP_INSTR`, default 0: value driven on `instr_D` whenever `valid_D` = 0.

**Ports**
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `stall` in 1: hold the decode register and stop issuing requests.
- `PCSrc` in 1: taken branch; redirect to `branch_target` and flush.
- `branch_target` in `ADDR_W`: redirect address, sampled when `PCSrc` = 1.
- `imem_req` out 1: read request this cycle (combinational).
- `imem_addr` out `ADDR_W`: read address; equals `pc_F`.
- `imem_rdata` in `INSTR_W`: read data, valid exactly one cycle after a request.
- `valid_D` out 1: decode register holds a real instruction.
- `pc_D` out `ADDR_W`: address of `instr_D`.
- `instr_D` out `INSTR_W`: registered instruction.
- `op` out 4: `instr_D[INSTR_W-1:INSTR_W-4]`, routed to `controlUnit.op`.
- `cond` out 1: `instr_D[INSTR_W-5]`, routed to `controlUnit.cond`.

## Operation
**Registers**
- `pc_F`
- in-flight tracker: `inf_v`, `inf_pc`
- skid buffer: `skid_v`, `skid_pc`, `skid_instr`
- decode register: `valid_D`, `pc_D`, `instr_D`

**Reset** (`rst` = 1 at an edge)
- `pc_F` ← `RESET_PC`.
- `inf_v`, `skid_v`, `valid_D` ← 0.
- `pc_D` ← 0; `instr_D` ← `NOP_INSTR`.
- `imem_req` = 0 whenever `rst` = 1.
- Reset applied mid-operation discards all in-flight and skid contents, with no partial state kept.

**Issue**
- `imem_req` = !`rst` & !`stall` & !`PCSrc`.
- On an issue: `inf_v` ← 1, `inf_pc` ← `pc_F`, `pc_F` ← `pc_F`+1.
- The increment wraps modulo 2^`ADDR_W` (all-ones → 0).
- No issue: `inf_v` ← 0 and `pc_F` holds.

**Skid state machine**
- States: EMPTY (`skid_v` = 0) and FULL (`skid_v` = 1).
- EMPTY → FULL: `stall` = 1 & `inf_v` = 1. Capture `imem_rdata` and `inf_pc`.
- FULL → EMPTY: `stall` = 0. The skid entry moves into the decode register.
- FULL with `stall` = 1: hold. No new response can arrive, because nothing is issued while stalled.

**Decode register load** (when `stall` = 0 and `PCSrc` = 0), in priority order:
1. Skid entry, if FULL.
2. Otherwise the in-flight response (`imem_rdata`, `inf_pc`), if `inf_v` = 1.
3. Otherwise a bubble: `valid_D` ← 0, `instr_D` ← `NOP_INSTR`.
- If `stall` = 1, the decode register holds.

**Redirect** (`PCSrc` = 1) has priority over `stall`:
- `pc_F` ← `branch_target`.
- `inf_v` ← 0, `skid_v` ← 0.
- `valid_D` ← 0, `instr_D` ← `NOP_INSTR`.
- No request is issued that cycle.

## Timing
- **Fetch latency:** a request issued in cycle n returns data in cycle n+1. That instruction is visible on `valid_D`/`instr_D` from cycle n+2.
- **First fetch after reset:** the first cycle with `rst` = 0 is cycle 0, with `imem_addr` = `RESET_PC`. `valid_D` = 1 with `pc_D` = `RESET_PC` from cycle 2.
- **Steady state:** with no stall, one instruction per cycle and consecutive `pc_D` values.
- **Stall:** a stall asserted in cycle n holds `instr_D` from cycle n+1 onward. The response for the cycle n−1 request goes to the skid buffer.
- **Stall release:** released in cycle m, the skid entry is visible at m+1. The request issued in m is visible at m+2. No gap and no duplicate.
- **Redirect:** `PCSrc` in cycle n gives `valid_D` = 0 at n+1 and n+2. The target instruction is visible at n+3.
- **Same-cycle stall and redirect:** the redirect wins and the stall is ignored for that cycle.
- **Outputs:** `op` and `cond` are purely combinational from `instr_D`.

## Test plan
- **Reset then run:** `RESET_PC` = 0, memory word k = k. Expect `pc_D` = 0,1,2,3 with `valid_D` = 1 from cycle 2, and `op`/`cond` matching word bits.
- **Single-cycle stall:** `stall` asserted in cycle 5. `instr_D` must hold for one extra cycle, then resume with no skipped or repeated `pc_D`.
- **Long stall:** `stall` held for cycles 5–9. `imem_req` = 0 throughout, `skid_v` = 1 from cycle 6, and the instruction sequence after release is contiguous.
- **Branch:** `PCSrc` = 1 with `branch_target` = 0x0040 in cycle 6. Expect two bubbles (`valid_D` = 0, `instr_D` = `NOP_INSTR`), then `pc_D` = 0x0040, 0x0041.
- **Branch during stall with full skid:** `PCSrc` asserted while stalled. The skid entry is discarded, and the next valid `pc_D` is the target three cycles later.
- **PC wrap and mid-run reset:** start at `branch_target` = 0xFFFE. Expect `pc_D` = 0xFFFE, 0xFFFF, 0x0000. Then assert `rst` for one cycle mid-stream: `valid_D` = 0 the next cycle and the fetch restarts at `RESET_PC`.
